// File: rtl/shift_io_ctrl.sv
// -----------------------------------------------------------------------------
// shift_io_ctrl
//   Full-duplex serial I/O controller for a 74HC165 (parallel-in) chain and a
//   74HC595 (parallel-out) chain that share one shift clock. Each transfer
//   parallel-loads the 165s, clocks NBIT bits out of Wr_Data_I and NBIT bits in
//   from Ser_I, strobes the 595 storage latch and publishes the word read back.
//   Transfers start on Start_I or on an optional periodic scan tick.
//
// Parameters
//   NBIT        chain length in bits (>=1)
//   CLKDIV      Clk_I cycles per serial-clock half period (>=1)
//   SCAN_PERIOD Clk_I cycles between automatic transfers (0 disables)
//
// Ports
//   Clk_I      system clock, rising edge
//   Rst_I      asynchronous active-high reset
//   Start_I    transfer request, honoured only while idle
//   Wr_Data_I  word shifted out to the 595 chain (MSB first)
//   Ser_I      serial data from the 165 QH pin
//   SClk_O     shared shift clock
//   SH_LD_O    165 SH/LD (0 = parallel load, 1 = shift)
//   Ser_O      serial data to the 595 SER pin
//   RClk_O     595 storage latch strobe
//   Rd_Data_O  last word read from the 165 chain
//   Busy_O     high whenever a transfer is in progress
//   Done_O     one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_io_ctrl #(
  parameter int NBIT        = 8,
  parameter int CLKDIV      = 4,
  parameter int SCAN_PERIOD = 1000
) (
  input  logic            Clk_I,
  input  logic            Rst_I,
  input  logic            Start_I,
  input  logic [NBIT-1:0] Wr_Data_I,
  input  logic            Ser_I,
  output logic            SClk_O,
  output logic            SH_LD_O,
  output logic            Ser_O,
  output logic            RClk_O,
  output logic [NBIT-1:0] Rd_Data_O,
  output logic            Busy_O,
  output logic            Done_O
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam int SW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBIT - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'((SCAN_PERIOD > 0) ? SCAN_PERIOD - 1 : 0);
  localparam bit            SCAN_EN   = (SCAN_PERIOD > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            phase_q, phase_d;   // 0 = low half of a slot, 1 = high half
  logic [NBIT-1:0] tx_q, tx_d;
  logic [NBIT-1:0] rx_q, rx_d;
  logic [NBIT-1:0] rd_q, rd_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic            pend_q, pend_d;     // scan tick that arrived while busy

  logic            sclk_q, shld_q, rclk_q, busy_q, done_q;

  logic            div_end;
  logic            scan_hit;

  assign div_end  = (div_q == DIV_LAST);
  assign scan_hit = SCAN_EN && (scan_q == SCAN_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    pend_d  = pend_q;

    if (!SCAN_EN || scan_hit) begin
      scan_d = '0;
    end else begin
      scan_d = scan_q + 1'b1;
    end
    if (scan_hit && (state_q != S_IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        div_d   = '0;
        bit_d   = '0;
        phase_d = 1'b0;
        // Start, a fresh tick and a held-over tick all collapse into one transfer.
        if (Start_I || scan_hit || pend_q) begin
          tx_d    = Wr_Data_I;
          pend_d  = 1'b0;
          scan_d  = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (div_end) begin
          div_d   = '0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!phase_q) begin
            // Last low cycle: QH is settled, capture it before the rising edge.
            rx_d    = rx_q << 1;
            rx_d[0] = Ser_I;
            phase_d = 1'b1;
          end else begin
            // End of high half: advance the next TX bit onto Ser_O.
            tx_d    = tx_q << 1;
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = S_LATCH;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end

      S_LATCH: begin
        if (div_q == '0) begin
          rd_d = rx_q;
        end
        if (div_end) begin
          div_d   = '0;
          state_d = S_DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; pin strobes are registered from the next
  // state so every external control line comes straight off a flop.
  always_ff @(posedge Clk_I or posedge Rst_I) begin
    if (Rst_I) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      scan_q  <= '0;
      pend_q  <= 1'b0;
      sclk_q  <= 1'b0;
      shld_q  <= 1'b1;
      rclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      scan_q  <= scan_d;
      pend_q  <= pend_d;
      sclk_q  <= (state_d == S_SHIFT) && phase_d;
      shld_q  <= (state_d != S_LOAD);
      rclk_q  <= (state_d == S_LATCH);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign SClk_O    = sclk_q;
  assign SH_LD_O   = shld_q;
  assign RClk_O    = rclk_q;
  assign Busy_O    = busy_q;
  assign Done_O    = done_q;
  assign Ser_O     = tx_q[NBIT-1];
  assign Rd_Data_O = rd_q;

endmodule

// File: doc/shift_io_ctrl.md
SHIFT_IO_CTRL -- requirements
Module: shift_io_ctrl

Interface
REQ-001 Parameter NBIT, default 8, chain length in bits for both the input and output shift registers (>=1).
REQ-002 Parameter CLKDIV, default 4, Clk_I cycles per serial-clock half period (>=1).
REQ-003 Parameter SCAN_PERIOD, default 1000, Clk_I cycles between automatic transfers (0 = auto-scan disabled).
REQ-004 Clk_I  in  1  system clock; all state changes on rising edge.
REQ-005 Rst_I  in  1  reset, asynchronous, active-high.
REQ-006 Start_I  in  1  request one full-duplex transfer; sampled only in IDLE.
REQ-007 Wr_Data_I  in  NBIT  parallel word to shift out to the 74HC595 chain.
REQ-008 Ser_I  in  1  serial data from the 74HC165 QH pin.
REQ-009 SClk_O  out  1  shared shift clock to both chains.
REQ-010 SH_LD_O  out  1  74HC165 SH/LD: 0 = parallel load, 1 = shift.
REQ-011 Ser_O  out  1  serial data to the 74HC595 SER pin.
REQ-012 RClk_O  out  1  74HC595 storage-register latch strobe.
REQ-013 Rd_Data_O  out  NBIT  last word read from the 74HC165 chain.
REQ-014 Busy_O  out  1  high in every state except IDLE.
REQ-015 Done_O  out  1  one-cycle pulse when a transfer completes.

Function
REQ-016 FSM states IDLE, LOAD, SHIFT, LATCH, DONE; one transfer moves strictly in that order.
REQ-017 IDLE: SClk_O=0, SH_LD_O=1, RClk_O=0; on Start_I=1 or scan tick, capture Wr_Data_I into the TX shift register and enter LOAD next cycle.
REQ-018 LOAD: SH_LD_O=0 for exactly CLKDIV cycles, SClk_O=0, then SHIFT.
REQ-019 SHIFT: NBIT bit slots, each CLKDIV cycles with SClk_O=0 followed by CLKDIV cycles with SClk_O=1; SH_LD_O=1 throughout.
REQ-020 Ser_O = TX MSB during each slot; TX shifts left by one at the end of each slot's high phase.
REQ-021 Ser_I is sampled on the last cycle of each slot's low phase and shifted into the RX register LSB (shift left); first received bit ends in bit NBIT-1.
REQ-022 After slot NBIT-1 high phase, SClk_O returns to 0 and state is LATCH.
REQ-023 LATCH: RClk_O=1 for exactly CLKDIV cycles; Rd_Data_O <= RX on the first LATCH cycle.
REQ-024 DONE: Done_O=1 for one cycle, then IDLE; Rd_Data_O is stable from DONE until the next LATCH.
REQ-025 Latency: Start_I sampled at edge k -> Done_O high in cycle k+(2*NBIT+2)*CLKDIV+1 (73 for defaults).
REQ-026 Start_I while Busy_O=1 is ignored, not queued.
REQ-027 Scan counter increments every cycle, clears when any transfer starts; reaching SCAN_PERIOD-1 in IDLE produces a scan tick; reaching it while busy holds the tick pending until IDLE.
REQ-028 Start_I and scan tick in the same cycle start exactly one transfer.
REQ-029 SH_LD_O and RClk_O never change in the same cycle as a SClk_O rising edge.

Reset
REQ-030 Rst_I=1 forces immediately, regardless of state: IDLE, SClk_O=0, SH_LD_O=1, Ser_O=0, RClk_O=0, Busy_O=0, Done_O=0, Rd_Data_O=0, TX/RX=0, scan counter=0.
REQ-031 Reset mid-transfer aborts it; Rd_Data_O and Done_O are not updated/pulsed for the aborted transfer.

Verification
REQ-032 Defaults, 74HC165 model loaded with 0xA5, Start_I pulse with Wr_Data_I=0x3C -> 8 SClk_O rising edges, 595 model latches 0x3C, Rd_Data_O=0xA5, Done_O at cycle 73.
REQ-033 Start_I held high for 200 cycles, SCAN_PERIOD=0 -> back-to-back transfers, Done_O every 74 cycles, no extra transfer from mid-transfer Start_I.
REQ-034 SCAN_PERIOD=100, Start_I=0, input 0xFF then 0x00 -> automatic transfers every 100 cycles, Rd_Data_O tracks 0xFF then 0x00.
REQ-035 Rst_I asserted in SHIFT slot 4 -> outputs at REQ-030 values same cycle, no Done_O; next Start_I completes normally.
REQ-036 NBIT=16, CLKDIV=1, input 0x8001 -> Rd_Data_O=0x8001, Done_O at cycle 35, SH_LD_O low exactly 1 cycle.
